// File: rtl/sigmoid_pkg.sv
// Shared fixed-point definitions for the neuron MAC and the sigmoid stage.
// Q4.12 data, Q8.24 products, 40-bit wrapping accumulator.
package sigmoid_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 12;
    localparam int ACC_W     = 40;
    localparam int PROD_W    = 2 * DATA_W;

    typedef logic signed [DATA_W-1:0] q4_12_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Stage-1 register contents: one multiplied element plus its framing flags.
    typedef struct packed {
        logic   valid;
        logic   last;
        logic   first;
        prod_t  prod;
        q4_12_t bias;
    } mac_s1_t;

    // Bias is Q4.12; aligning it to the Q8.24 product scale needs a FRAC_BITS shift.
    function automatic acc_t bias_to_acc(input q4_12_t bias);
        return acc_t'(bias) <<< FRAC_BITS;
    endfunction

    function automatic acc_t prod_to_acc(input prod_t prod);
        return acc_t'(prod);
    endfunction

endpackage

// File: rtl/neuron_round_sat.sv
// Converts the Q8.24 accumulator to Q4.12: round half up, then clamp to the
// 16-bit signed range, flagging any clamp.
module neuron_round_sat
    import sigmoid_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] data_o,
    output logic                     sat_o
);

    // One extra bit keeps the +half addition free of overflow for any acc value.
    localparam int SUM_W = ACC_W + 1;
    localparam int SH_W  = SUM_W - FRAC_BITS;
    localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_BITS - 1);

    logic [SUM_W-1:0] sum;
    logic [SH_W-1:0]  shifted;
    logic             pos_ovf;
    logic             neg_ovf;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        sum     = {acc_i[ACC_W-1], acc_i} + HALF;
        shifted = sum[SUM_W-1:FRAC_BITS];
        pos_ovf = !shifted[SH_W-1] && (|shifted[SH_W-2:DATA_W-1]);
        neg_ovf =  shifted[SH_W-1] && !(&shifted[SH_W-2:DATA_W-1]);
        sat_o   = pos_ovf || neg_ovf;
        data_o  = shifted[DATA_W-1:0];
        if (pos_ovf) begin
            data_o = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (neg_ovf) begin
            data_o = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming dot-product neuron: multiply, accumulate with bias, then
// round/saturate to Q4.12 with one registered result per completed vector.
module neuron_mac
    import sigmoid_pkg::*;
#(
    parameter int MAX_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              last_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic [DATA_W-1:0] bias_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              sat_out,
    output logic              len_err_out
);

    localparam int               CNT_W   = $clog2(MAX_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN + 1);

    q4_12_t data_s;
    q4_12_t weight_s;
    q4_12_t bias_s;

    mac_s1_t s1_q, s1_d;
    logic    first_q, first_d;

    acc_t             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic              valid_out_q, valid_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              sat_out_q, sat_out_d;
    logic              len_err_q, len_err_d;

    logic signed [DATA_W-1:0] rs_data;
    logic                     rs_sat;

    assign data_s   = q4_12_t'(data_in);
    assign weight_s = q4_12_t'(weight_in);
    assign bias_s   = q4_12_t'(bias_in);

    always_comb begin
        s1_d       = '0;
        s1_d.valid = valid_in;
        s1_d.last  = valid_in && last_in;
        s1_d.first = first_q;
        s1_d.prod  = prod_t'(data_s) * prod_t'(weight_s);
        s1_d.bias  = bias_s;
        first_d    = valid_in ? last_in : first_q;
    end

    // Idle cycles leave acc and count untouched; a first element ignores the old acc.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (s1_q.valid) begin
            acc_d  = (s1_q.first ? bias_to_acc(s1_q.bias) : acc_q) + prod_to_acc(s1_q.prod);
            cnt_d  = s1_q.first ? CNT_W'(1)
                   : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            done_d = s1_q.last;
        end
    end

    neuron_round_sat u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    always_comb begin
        valid_out_d = done_q;
        data_out_d  = data_out_q;
        sat_out_d   = sat_out_q;
        len_err_d   = len_err_q;
        if (done_q) begin
            data_out_d = rs_data;
            sat_out_d  = rs_sat;
            len_err_d  = cnt_q > CNT_LIM;
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            first_q     <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            sat_out_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            sat_out_q   <= sat_out_d;
            len_err_q   <= len_err_d;
        end
    end

    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign sat_out     = sat_out_q;
    assign len_err_out = len_err_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: directed and random vectors compared
// against an arithmetic reference model, including result timing.
module tb_neuron_mac;

    localparam int MAX_LEN = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        last_in;
    logic [15:0] data_in;
    logic [15:0] weight_in;
    logic [15:0] bias_in;
    logic        valid_out;
    logic [15:0] data_out;
    logic        sat_out;
    logic        len_err_out;

    neuron_mac #(.MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .last_in     (last_in),
        .data_in     (data_in),
        .weight_in   (weight_in),
        .bias_in     (bias_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .sat_out     (sat_out),
        .len_err_out (len_err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        logic        len_err;
        int          cyc;
    } res_t;

    res_t        exp_q[$];
    res_t        obs_q[$];
    logic [15:0] vd[$];
    logic [15:0] vw[$];
    int          cycle_cnt = 0;
    int          checks    = 0;
    int          failures  = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        if (valid_out === 1'b1) obs_q.push_back('{data_out, sat_out, len_err_out, cycle_cnt});
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: exact integer dot product, wrapped to 40 bits, rounded half up, clamped.
    function automatic res_t model(input logic [15:0] bias);
        longint      acc;
        logic [39:0] a40;
        longint      r;
        res_t        e;
        acc = longint'($signed(bias)) * 4096;
        foreach (vd[i]) acc += longint'($signed(vd[i])) * longint'($signed(vw[i]));
        a40 = acc[39:0];
        acc = longint'($signed(a40));
        r   = (acc + 2048) >>> 12;
        e.sat = 1'b0;
        if (r > 32767) begin
            r = 32767; e.sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; e.sat = 1'b1;
        end
        e.data    = r[15:0];
        e.len_err = vd.size() > MAX_LEN;
        e.cyc     = 0;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in  = 1'b0;
            last_in   = 1'($urandom);
            data_in   = 16'($urandom);
            weight_in = 16'($urandom);
            bias_in   = 16'($urandom);
        end
    endtask

    // Drives vd/vw as one vector; leaves valid_in high so the next call is back-to-back.
    task automatic send_vec(input logic [15:0] bias, input int gap);
        res_t e;
        int   n;
        e = model(bias);
        n = vd.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in  = 1'b1;
            last_in   = (i == n - 1);
            data_in   = vd[i];
            weight_in = vw[i];
            bias_in   = (i == 0) ? bias : 16'($urandom);
            if (i == n - 1) e.cyc = cycle_cnt + 3;
            if (i < n - 1) idle(gap);
        end
        exp_q.push_back(e);
    endtask

    task automatic set_vec1(input logic [15:0] d, input logic [15:0] w);
        vd = '{d};
        vw = '{w};
    endtask

    task automatic drain(input string tag);
        res_t e, o;
        int   budget = 80;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_data"}, o.data, e.data);
            check({tag, "_sat"}, o.sat, e.sat);
            check({tag, "_len_err"}, o.len_err, e.len_err);
            check({tag, "_cycle"}, o.cyc, e.cyc);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        last_in   = 1'b0;
        data_in   = '0;
        weight_in = '0;
        bias_in   = '0;
        repeat (3) @(negedge clk);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_sat_out", sat_out, 1'b0);
        check("rst_len_err", len_err_out, 1'b0);
        rst = 1'b0;
        idle(2);

        // Single element, unit times unit.
        set_vec1(16'h1000, 16'h1000);
        send_vec(16'h0000, 0);
        idle(1);
        drain("single");
        check("single_hold", data_out, 16'h1000);

        // Three elements with bias, contiguous then with idle gaps.
        vd = '{16'h2000, 16'h1000, 16'h0400};
        vw = '{16'h0800, 16'hF000, 16'h0400};
        send_vec(16'h0100, 0);
        idle(1);
        drain("three_contig");
        check("three_contig_hold", data_out, 16'h0200);
        send_vec(16'h0100, 2);
        idle(1);
        drain("three_gap");
        check("three_gap_hold", data_out, 16'h0200);

        // Positive and negative saturation.
        vd = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vw = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        send_vec(16'h0000, 0);
        idle(1);
        drain("sat_pos");
        check("sat_pos_hold", {sat_out, data_out}, {1'b1, 16'h7FFF});
        set_vec1(16'h8000, 16'h7FFF);
        send_vec(16'h0000, 0);
        idle(1);
        drain("sat_neg");
        check("sat_neg_hold", {sat_out, data_out}, {1'b1, 16'h8000});

        // Rounding boundaries, issued back-to-back.
        set_vec1(16'h0001, 16'h0800);
        send_vec(16'h0000, 0);
        set_vec1(16'hFFFF, 16'h0800);
        send_vec(16'h0000, 0);
        set_vec1(16'h0001, 16'h07FF);
        send_vec(16'h0000, 0);
        idle(1);
        drain("round");

        // Back-to-back single-element vectors.
        set_vec1(16'h1000, 16'h1000);
        send_vec(16'h0000, 0);
        set_vec1(16'h1000, 16'hF000);
        send_vec(16'h0000, 0);
        idle(1);
        drain("b2b");
        check("b2b_hold", data_out, 16'hF000);

        // Length boundary: MAX_LEN elements is fine, MAX_LEN+1 flags an error.
        vd.delete(); vw.delete();
        for (int i = 0; i < MAX_LEN; i++) begin
            vd.push_back(16'($urandom_range(0, 511)));
            vw.push_back(16'($urandom));
        end
        send_vec(16'($urandom), 0);
        vd.delete(); vw.delete();
        for (int i = 0; i < MAX_LEN + 1; i++) begin
            vd.push_back(16'h0000);
            vw.push_back(16'h0000);
        end
        send_vec(16'h0000, 0);
        idle(1);
        drain("len");
        check("len_err_hold", len_err_out, 1'b1);

        // Randomized vectors with random gaps, chained back-to-back.
        for (int v = 0; v < 12; v++) begin
            int len;
            len = $urandom_range(1, 8);
            vd.delete(); vw.delete();
            for (int i = 0; i < len; i++) begin
                vd.push_back(16'($urandom));
                vw.push_back(16'($urandom));
            end
            send_vec(16'($urandom), $urandom_range(0, 2));
        end
        idle(1);
        drain("random");

        // Reset aborts a vector with its last element in flight, then a partial vector.
        @(negedge clk);
        valid_in = 1'b1; last_in = 1'b1; data_in = 16'h1000; weight_in = 16'h1000; bias_in = 16'h0000;
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_async_valid", valid_out, 1'b0);
        check("rst_async_data", data_out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        valid_in = 1'b1; last_in = 1'b0; data_in = 16'h2000; weight_in = 16'h2000; bias_in = 16'h0400;
        @(negedge clk);
        data_in = 16'h3000;
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_vec1(16'h1000, 16'h1000);
        send_vec(16'h0000, 0);
        idle(1);
        drain("rst_mid");
        check("rst_mid_hold", data_out, 16'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
